matrix_frame_scheduler: RTL and testbench
=========================================

// Module: matrix_frame_scheduler
// PURPOSE
//  Row-scan controller for the 8x16 LED matrix (MATRIX_ROW/MATRIX_COL), sitting between snakeCtrl and the pins.
//  Double-buffered frame store: game logic writes the back bank row-by-row and requests a swap.
//  The swap occurs only at a frame boundary, so a displayed frame never tears.
//  Inserts a blanking interval before each row to suppress ghosting.
// PARAMETERS
//  CLK_DIV       1024  clk cycles each row is lit (SHOW phase); must be >= 2
//  BLANK_CYCLES  16    clk cycles all rows/cols are off before each row (BLANK phase); must be >= 1
// PORTS
//  clk          in   1   single system clock (MCLK at top level)
//  rst_n        in   1   asynchronous, active-low reset
//  wr_en        in   1   write back-bank row this cycle
//  wr_row       in   3   row index 0..7
//  wr_data      in   16  row pixels, 1 = lit, bit i -> column i
//  swap_req     in   1   request front/back swap at next frame boundary
//  swap_ack     out  1   one-cycle pulse in the cycle the swap happens
//  frame_start  out  1   one-cycle pulse when scan wraps row 7 -> row 0
//  MATRIX_ROW   out  8   row select, active-low, one-hot-low during SHOW
//  MATRIX_COL   out  16  column drive, active-low (0 = lit)
// BEHAVIOUR
//  - Async reset values: MATRIX_ROW=8'hFF, MATRIX_COL=16'hFFFF, swap_ack=0, frame_start=0.
//    Internal reset: both banks cleared to 0, front=bank A, row=0, state=BLANK, cnt=0, pending=0.
//  - FSM BLANK: rows/cols all off. After BLANK_CYCLES cycles -> SHOW. On entry, latch ~front[row] into a col register.
//  - FSM SHOW: MATRIX_ROW = ~(8'b1<<row), MATRIX_COL = latched value; held for CLK_DIV cycles.
//    Then row = row+1 (7 wraps to 0) and -> BLANK.
//  - Timing: row period = BLANK_CYCLES+CLK_DIV; frame period = 8*(BLANK_CYCLES+CLK_DIV). All outputs are registered.
//  - Counter: width $clog2(max(CLK_DIV,BLANK_CYCLES)+1); reloads to 0 on every phase change.
//  - Write: wr_en=1 -> back[wr_row] <= wr_data on the next edge; the front bank is never writable.
//  - Swap handshake:
//    - swap_req=1 sets pending. Further requests while pending merge into the same swap.
//    - At the last SHOW cycle of row 7, if pending: front <= back, pending cleared, swap_ack=1 for that one cycle.
//    - The new front is shown from row 0 of the next frame.
//    - After a swap, the back bank holds the previous front contents; there is no copy.
//    - swap_req=1 in the ack cycle is ignored. swap_req still 1 on the cycle after ack sets a new pending.
//  - Simultaneous write and swap: the write targets the pre-swap back bank (the new front) and is visible from row 0.
//  - frame_start: asserted in the same cycle as the row 7 -> row 0 transition (coincides with swap_ack when swapping).
//    Not asserted after reset release.
//  - Reset mid-frame: outputs go off immediately. Scan restarts at BLANK row 0. Pending swap and bank data are lost.
// STRUCTURE
//  - matrix_defs.vh (shared header): MATRIX_ROWS=8, MATRIX_COLS=16, ROW_OFF=8'hFF, COL_OFF=16'hFFFF, FSM state codes.
//  - Sub-module matrix_frame_bank: two 8x16 register banks with a front-select bit.
//    Interface: one write port to the back bank, one combinational read port to the front bank, async clear on rst_n.
//  - Top holds the FSM, counters, pending/ack logic and output registers.
// TESTING (CLK_DIV=4, BLANK_CYCLES=2 -> 6-cycle row, 48-cycle frame)
//  1. Hold rst_n low 3 cycles, release -> ROW=FF, COL=FFFF for 2 cycles.
//     Then ROW=FE, COL=FFFF for 4 cycles; frame_start first pulses 48 cycles after release.
//  2. Write row 3 = 16'hA5A5, no swap -> COL stays FFFF for 3 frames, no swap_ack.
//  3. Continue test 2 with a 1-cycle swap_req mid-frame -> one swap_ack, coincident with frame_start.
//     In the next frame, row 3 shows ROW=F7, COL=5A5A; other rows show FFFF.
//  4. Two swap_req pulses 10 cycles apart in one frame -> exactly one swap_ack.
//     Back bank then reads the old front (all 0).
//  5. wr_en with row 0 = 16'h0001 in the same cycle as swap_ack -> next frame row 0 shows COL=FFFE.
//  6. Assert rst_n low during SHOW of row 5 with swap pending -> outputs FF/FFFF asynchronously, before the next edge.
//     After release: no swap_ack, and the display is blank (banks cleared).

Source files
------------

// File: rtl/matrix_frame_scheduler_pkg.sv
// Shared matrix geometry, idle output levels and scan-state encoding for the
// LED matrix frame scheduler.
package matrix_frame_scheduler_pkg;

    localparam int MATRIX_ROWS = 8;
    localparam int MATRIX_COLS = 16;
    localparam int ROW_W       = $clog2(MATRIX_ROWS);

    localparam logic [MATRIX_ROWS-1:0] ROW_OFF = 8'hFF;
    localparam logic [MATRIX_COLS-1:0] COL_OFF = 16'hFFFF;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } scan_state_e;

    // Active-low one-hot row select.
    function automatic logic [MATRIX_ROWS-1:0] row_select(input logic [ROW_W-1:0] row);
        return ~(MATRIX_ROWS'(1) << row);
    endfunction

endpackage

// File: rtl/matrix_frame_scheduler_if.sv
// Bundle of the game-logic write/swap handshake and the matrix pin drive.
interface matrix_frame_scheduler_if;
    import matrix_frame_scheduler_pkg::*;

    logic                   wr_en;
    logic [ROW_W-1:0]       wr_row;
    logic [MATRIX_COLS-1:0] wr_data;
    logic                   swap_req;
    logic                   swap_ack;
    logic                   frame_start;
    logic [MATRIX_ROWS-1:0] MATRIX_ROW;
    logic [MATRIX_COLS-1:0] MATRIX_COL;

    modport master (
        output wr_en, wr_row, wr_data, swap_req,
        input  swap_ack, frame_start, MATRIX_ROW, MATRIX_COL
    );

    modport slave (
        input  wr_en, wr_row, wr_data, swap_req,
        output swap_ack, frame_start, MATRIX_ROW, MATRIX_COL
    );

endinterface

// File: rtl/matrix_frame_scheduler_bank.sv
// Two 8x16 pixel banks with a front-select bit: writes land in the back bank,
// the scan reads the front bank combinationally.
module matrix_frame_scheduler_bank
    import matrix_frame_scheduler_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_wr_en,
    input  logic [ROW_W-1:0]       i_wr_row,
    input  logic [MATRIX_COLS-1:0] i_wr_data,
    input  logic                   i_swap,
    input  logic [ROW_W-1:0]       i_rd_row,
    output logic [MATRIX_COLS-1:0] o_rd_data
);

    logic [MATRIX_COLS-1:0] r_bank_a [MATRIX_ROWS];
    logic [MATRIX_COLS-1:0] r_bank_b [MATRIX_ROWS];
    logic                   r_front_sel;

    // A write coinciding with a swap uses the old select, so it lands in the new front.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MATRIX_ROWS; i++) begin
                r_bank_a[i] <= '0;
                r_bank_b[i] <= '0;
            end
            r_front_sel <= 1'b0;
        end else begin
            if (i_wr_en) begin
                if (r_front_sel) r_bank_a[i_wr_row] <= i_wr_data;
                else             r_bank_b[i_wr_row] <= i_wr_data;
            end
            if (i_swap) r_front_sel <= ~r_front_sel;
        end
    end

    assign o_rd_data = r_front_sel ? r_bank_b[i_rd_row] : r_bank_a[i_rd_row];

endmodule

// File: rtl/matrix_frame_scheduler.sv
// Row-scan controller for the 8x16 LED matrix: blank/show phases per row,
// double-buffered frame store swapped only at the frame boundary.
module matrix_frame_scheduler
    import matrix_frame_scheduler_pkg::*;
#(
    parameter int CLK_DIV      = 1024,
    parameter int BLANK_CYCLES = 16
)
(
    input  logic                    clk,
    input  logic                    rst_n,
    matrix_frame_scheduler_if.slave bus
);

    localparam int CNT_MAX = (CLK_DIV > BLANK_CYCLES) ? CLK_DIV : BLANK_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] SHOW_PRE   = CNT_W'(CLK_DIV - 2);
    localparam logic [ROW_W-1:0] LAST_ROW   = ROW_W'(MATRIX_ROWS - 1);

    scan_state_e            r_state, w_state_nxt;
    logic [CNT_W-1:0]       r_cnt, w_cnt_nxt;
    logic [ROW_W-1:0]       r_row, w_row_nxt;
    logic [MATRIX_ROWS-1:0] r_row_out, w_row_out_nxt;
    logic [MATRIX_COLS-1:0] r_col_out, w_col_out_nxt;
    logic                   r_swap_ack, w_swap_ack_nxt;
    logic                   r_frame_start, w_frame_start_nxt;
    logic                   r_pending, w_pending_nxt;
    logic                   w_swap;
    logic [MATRIX_COLS-1:0] w_front_row;

    matrix_frame_scheduler_bank u_bank (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_wr_en   (bus.wr_en),
        .i_wr_row  (bus.wr_row),
        .i_wr_data (bus.wr_data),
        .i_swap    (w_swap),
        .i_rd_row  (r_row),
        .o_rd_data (w_front_row)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_BLANK;
            r_cnt         <= '0;
            r_row         <= '0;
            r_row_out     <= ROW_OFF;
            r_col_out     <= COL_OFF;
            r_swap_ack    <= 1'b0;
            r_frame_start <= 1'b0;
            r_pending     <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_row         <= w_row_nxt;
            r_row_out     <= w_row_out_nxt;
            r_col_out     <= w_col_out_nxt;
            r_swap_ack    <= w_swap_ack_nxt;
            r_frame_start <= w_frame_start_nxt;
            r_pending     <= w_pending_nxt;
        end
    end

    // The ack/frame_start pulses are registered one cycle ahead so they are
    // high during the final SHOW cycle of row 7, whose closing edge flips the banks.
    always_comb begin
        w_state_nxt       = r_state;
        w_cnt_nxt         = r_cnt + 1'b1;
        w_row_nxt         = r_row;
        w_row_out_nxt     = r_row_out;
        w_col_out_nxt     = r_col_out;
        w_swap_ack_nxt    = 1'b0;
        w_frame_start_nxt = 1'b0;
        w_swap            = 1'b0;
        w_pending_nxt     = r_swap_ack ? 1'b0 : (r_pending | bus.swap_req);

        case (r_state)
            ST_BLANK: begin
                if (r_cnt == BLANK_LAST) begin
                    w_state_nxt   = ST_SHOW;
                    w_cnt_nxt     = '0;
                    w_row_out_nxt = row_select(r_row);
                    w_col_out_nxt = ~w_front_row;
                end
            end
            ST_SHOW: begin
                if (r_row == LAST_ROW && r_cnt == SHOW_PRE) begin
                    w_swap_ack_nxt    = r_pending | bus.swap_req;
                    w_frame_start_nxt = 1'b1;
                end
                if (r_cnt == SHOW_LAST) begin
                    w_state_nxt   = ST_BLANK;
                    w_cnt_nxt     = '0;
                    w_row_nxt     = r_row + 1'b1;
                    w_row_out_nxt = ROW_OFF;
                    w_col_out_nxt = COL_OFF;
                    w_swap        = r_swap_ack;
                end
            end
            default: begin
                w_state_nxt = ST_BLANK;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign bus.MATRIX_ROW  = r_row_out;
    assign bus.MATRIX_COL  = r_col_out;
    assign bus.swap_ack    = r_swap_ack;
    assign bus.frame_start = r_frame_start;

endmodule

// File: tb/tb_matrix_frame_scheduler.sv
// Self-checking bench for matrix_frame_scheduler with CLK_DIV=4, BLANK_CYCLES=2
// (6-cycle rows, 48-cycle frames); displayed rows are scored against a bank model.
module tb_matrix_frame_scheduler;

    localparam int FRAME = 48;

    typedef struct packed {
        logic [7:0]  row;
        logic [15:0] col;
    } row_exp_t;

    logic clk;
    logic rst_n;
    matrix_frame_scheduler_if bus ();

    matrix_frame_scheduler #(.CLK_DIV(4), .BLANK_CYCLES(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int          n_vec = 0;
    int          n_err = 0;
    row_exp_t    row_q[$];
    row_exp_t    mon_e;
    logic [7:0]  prev_row = 8'hFF;
    logic [15:0] mdl_front [8];
    logic [15:0] mdl_back  [8];
    bit          mdl_pend;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Each row that enters SHOW is popped from the scoreboard and checked.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_row = 8'hFF;
        end else begin
            if (bus.MATRIX_ROW !== 8'hFF && prev_row === 8'hFF) begin
                n_vec++;
                if (row_q.size() == 0) begin
                    n_err++;
                    $display("FAIL row_sb_empty: ROW=%h COL=%h shown, nothing expected",
                             bus.MATRIX_ROW, bus.MATRIX_COL);
                end else begin
                    mon_e = row_q.pop_front();
                    if ({bus.MATRIX_ROW, bus.MATRIX_COL} !== {mon_e.row, mon_e.col}) begin
                        n_err++;
                        $display("FAIL row_sb: got ROW=%h COL=%h expected ROW=%h COL=%h",
                                 bus.MATRIX_ROW, bus.MATRIX_COL, mon_e.row, mon_e.col);
                    end
                end
            end
            prev_row = bus.MATRIX_ROW;
        end
    end

    task automatic model_clear();
        for (int i = 0; i < 8; i++) begin
            mdl_front[i] = 16'h0000;
            mdl_back[i]  = 16'h0000;
        end
        mdl_pend = 1'b0;
    endtask

    task automatic push_frame_rows();
        row_exp_t e;
        for (int i = 0; i < 8; i++) begin
            e.row = 8'hFF ^ (8'h01 << i);
            e.col = ~mdl_front[i];
            row_q.push_back(e);
        end
    endtask

    // Runs one frame starting at its first cycle: swap_req in the cycles set in
    // req_mask, optional write at cycle wr_at, per-cycle phase/pulse checks.
    task automatic frame(input string tag, input logic [47:0] req_mask,
                         input int wr_at, input logic [2:0] wr_r, input logic [15:0] wr_d);
        bit          ack_exp;
        int          r, ph;
        logic [7:0]  er;
        logic [15:0] tmp;
        ack_exp = mdl_pend || (|req_mask[46:0]);
        push_frame_rows();
        for (int p = 0; p < FRAME; p++) begin
            r  = p / 6;
            ph = p % 6;
            er = (ph < 2) ? 8'hFF : (8'hFF ^ (8'h01 << r));
            n_vec++;
            if (bus.MATRIX_ROW !== er) begin
                n_err++;
                $display("FAIL %s row_phase p=%0d: got ROW=%h expected %h", tag, p, bus.MATRIX_ROW, er);
            end
            if (ph < 2) begin
                n_vec++;
                if (bus.MATRIX_COL !== 16'hFFFF) begin
                    n_err++;
                    $display("FAIL %s blank_col p=%0d: got COL=%h expected FFFF", tag, p, bus.MATRIX_COL);
                end
            end
            n_vec++;
            if (bus.frame_start !== (p == FRAME - 1)) begin
                n_err++;
                $display("FAIL %s frame_start p=%0d: got %b expected %b", tag, p, bus.frame_start, (p == FRAME - 1));
            end
            n_vec++;
            if (bus.swap_ack !== (ack_exp && p == FRAME - 1)) begin
                n_err++;
                $display("FAIL %s swap_ack p=%0d: got %b expected %b", tag, p, bus.swap_ack, (ack_exp && p == FRAME - 1));
            end
            bus.swap_req = req_mask[p];
            bus.wr_en    = (p == wr_at);
            bus.wr_row   = wr_r;
            bus.wr_data  = wr_d;
            if (p == wr_at) mdl_back[wr_r] = wr_d;
            @(posedge clk); #1;
            bus.swap_req = 1'b0;
            bus.wr_en    = 1'b0;
        end
        if (ack_exp) begin
            for (int i = 0; i < 8; i++) begin
                tmp          = mdl_front[i];
                mdl_front[i] = mdl_back[i];
                mdl_back[i]  = tmp;
            end
        end
        mdl_pend = ack_exp ? 1'b0 : req_mask[47];
    endtask

    task automatic test_reset();
        rst_n        = 1'b0;
        bus.wr_en    = 1'b0;
        bus.wr_row   = 3'd0;
        bus.wr_data  = 16'h0000;
        bus.swap_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if (bus.MATRIX_ROW !== 8'hFF) begin n_err++; $display("FAIL reset_row: got %h expected FF", bus.MATRIX_ROW); end
        n_vec++;
        if (bus.MATRIX_COL !== 16'hFFFF) begin n_err++; $display("FAIL reset_col: got %h expected FFFF", bus.MATRIX_COL); end
        n_vec++;
        if (bus.swap_ack !== 1'b0) begin n_err++; $display("FAIL reset_ack: got %b expected 0", bus.swap_ack); end
        n_vec++;
        if (bus.frame_start !== 1'b0) begin n_err++; $display("FAIL reset_fs: got %b expected 0", bus.frame_start); end
        rst_n = 1'b1;
        model_clear();
        // frame_start is expected only in the 48th cycle after release
        frame("first_frame", 48'h0, -1, 3'd0, 16'h0000);
    endtask

    task automatic test_write_no_swap();
        frame("wr_no_swap0", 48'h0, 5, 3'd3, 16'hA5A5);
        frame("wr_no_swap1", 48'h0, -1, 3'd0, 16'h0000);
        frame("wr_no_swap2", 48'h0, -1, 3'd0, 16'h0000);
    endtask

    task automatic test_swap();
        frame("swap_req", 48'h1 << 20, -1, 3'd0, 16'h0000);
        frame("after_swap", 48'h0, -1, 3'd0, 16'h0000);
    endtask

    task automatic test_merge_requests();
        frame("merge", (48'h1 << 5) | (48'h1 << 15), -1, 3'd0, 16'h0000);
        frame("after_merge", 48'h0, -1, 3'd0, 16'h0000);
    endtask

    task automatic test_write_on_ack();
        frame("wr_on_ack", 48'h1 << 10, 47, 3'd0, 16'h0001);
        frame("after_wr_ack", 48'h0, -1, 3'd0, 16'h0000);
    endtask

    task automatic test_back_to_back();
        frame("req_held", (48'h1 << 46) | (48'h1 << 47), -1, 3'd0, 16'h0000);
        frame("req_held_tail", 48'h1, -1, 3'd0, 16'h0000);
        frame("idle", 48'h0, -1, 3'd0, 16'h0000);
        frame("req_last", 48'h1 << 47, -1, 3'd0, 16'h0000);
        frame("pend_carry", 48'h0, -1, 3'd0, 16'h0000);
        frame("settle", 48'h0, -1, 3'd0, 16'h0000);
    endtask

    task automatic test_reset_mid_frame();
        push_frame_rows();
        for (int p = 0; p < 33; p++) begin
            bus.swap_req = (p == 10);
            @(posedge clk); #1;
            bus.swap_req = 1'b0;
        end
        n_vec++;
        if (bus.MATRIX_ROW !== 8'hDF) begin n_err++; $display("FAIL mid_row5: got ROW=%h expected DF", bus.MATRIX_ROW); end
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (bus.MATRIX_ROW !== 8'hFF) begin n_err++; $display("FAIL async_row_off: got %h expected FF", bus.MATRIX_ROW); end
        n_vec++;
        if (bus.MATRIX_COL !== 16'hFFFF) begin n_err++; $display("FAIL async_col_off: got %h expected FFFF", bus.MATRIX_COL); end
        row_q.delete();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_clear();
        frame("post_reset0", 48'h0, -1, 3'd0, 16'h0000);
        frame("post_reset1", 48'h0, -1, 3'd0, 16'h0000);
    endtask

    initial begin
        test_reset();
        test_write_no_swap();
        test_swap();
        test_merge_requests();
        test_write_on_ack();
        test_back_to_back();
        test_reset_mid_frame();
        @(negedge clk);
        n_vec++;
        if (row_q.size() != 0) begin
            n_err++;
            $display("FAIL rows_unshown: %0d rows left, expected 0", row_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
